// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive-side control for the UART receiver. It synchronizes the raw serial
// line, finds and qualifies the start bit, and times mid-bit sampling. It
// issues one shift_strobe per bit (data bits plus stop bit) to an external
// shift register. Once the stop bit has been shifted in, it either pulses
// load_buffer or raises a sticky framing_error.
//
// Ports:
//   clk           in   system clock, rising-edge
//   rst           in   synchronous, active-high reset
//   serial_in     in   raw asynchronous RX line (idle high)
//   stop_bit      in   MSB of the downstream shift register
//   shift_strobe  out  1-cycle pulse: shift register samples the line
//   load_buffer   out  1-cycle pulse: RX buffer captures the packet
//   framing_error out  sticky: last frame's stop bit was 0
//   busy          out  high whenever the FSM is not IDLE
//   dbg_state     out  current FSM state encoding (observation only)
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
   parameter int CLKS_PER_BIT = 10,
   parameter int NUM_BITS     = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   input  logic       stop_bit,
   output logic       shift_strobe,
   output logic       load_buffer,
   output logic       framing_error,
   output logic       busy,
   output logic [2:0] dbg_state
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int TW   = $clog2(CLKS_PER_BIT);
   localparam int BW   = $clog2(NUM_BITS + 1);

   localparam logic [TW-1:0] HALF_M1  = TW'(HALF - 1);
   localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] CNT_LAST = BW'(NUM_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_RECEIVE = 3'd2,
      S_CHECK   = 3'd3,
      S_LOAD    = 3'd4
   } state_t;

   state_t          r_state;
   logic [TW-1:0]   r_timer;
   logic [BW-1:0]   r_bit_cnt;
   logic            r_ferr;
   logic            r_sync1;
   logic            r_rx_s;
   logic            r_rx_prev;

   state_t          w_state_nxt;
   logic [TW-1:0]   w_timer_nxt;
   logic [BW-1:0]   w_bit_cnt_nxt;
   logic            w_ferr_nxt;
   logic            w_shift_strobe;
   logic            w_start_edge;

   // Falling edge of the synchronized line. The edge flop resets to 1 like
   // the synchronizer, so a line already low at reset release never looks
   // like a fresh start bit.
   assign w_start_edge = r_rx_prev & ~r_rx_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1   <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
         r_state   <= S_IDLE;
         r_timer   <= '0;
         r_bit_cnt <= '0;
         r_ferr    <= 1'b0;
      end else begin
         r_sync1   <= serial_in;
         r_rx_s    <= r_sync1;
         r_rx_prev <= r_rx_s;
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_ferr    <= w_ferr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_timer_nxt    = r_timer;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_ferr_nxt     = r_ferr;
      w_shift_strobe = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_start_edge) begin
               w_state_nxt   = S_START;
               w_timer_nxt   = '0;
               w_bit_cnt_nxt = '0;
               w_ferr_nxt    = 1'b0;
            end
         end

         // Half a bit period in: a line back high means the edge was a glitch.
         S_START: begin
            if (r_timer == HALF_M1) begin
               w_timer_nxt = '0;
               w_state_nxt = r_rx_s ? S_IDLE : S_RECEIVE;
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end

         // Every full bit period after the qualified start point lands
         // mid-bit, so the strobe fires at the timer's terminal count.
         S_RECEIVE: begin
            if (r_timer == BIT_LAST) begin
               w_shift_strobe = 1'b1;
               w_timer_nxt    = '0;
               w_bit_cnt_nxt  = r_bit_cnt + BW'(1);
               if (r_bit_cnt == CNT_LAST) begin
                  w_state_nxt = S_CHECK;
               end
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end

         // The shift register has taken the final bit, so stop_bit is valid.
         S_CHECK: begin
            if (stop_bit) begin
               w_state_nxt = S_LOAD;
            end else begin
               w_ferr_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end

         S_LOAD: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign shift_strobe  = w_shift_strobe;
   assign load_buffer   = (r_state == S_LOAD);
   assign busy          = (r_state != S_IDLE);
   assign framing_error = r_ferr;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Directed bench for uart_rx_ctrl at CLKS_PER_BIT=10, NUM_BITS=9. A small
// model of the downstream 9-bit shift register feeds stop_bit back. An edge
// monitor logs event cycle numbers, and one initial block drives the
// directed steps and checks them.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

   localparam int CPB = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       serial_in;
   logic       stop_bit;
   logic       shift_strobe;
   logic       load_buffer;
   logic       framing_error;
   logic       busy;
   logic [2:0] dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   uart_rx_ctrl #(
      .CLKS_PER_BIT (CPB),
      .NUM_BITS     (9)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .serial_in     (serial_in),
      .stop_bit      (stop_bit),
      .shift_strobe  (shift_strobe),
      .load_buffer   (load_buffer),
      .framing_error (framing_error),
      .busy          (busy),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- downstream shift register model ----------------
   // Bits arrive LSB first and enter at the MSB, so after nine shifts
   // sr[8] is the stop bit and sr[7:0] is the data byte.
   logic [8:0] sr = 9'h1FF;
   always @(posedge clk) begin
      if (shift_strobe === 1'b1) sr <= {serial_in, sr[8:1]};
   end
   assign stop_bit = sr[8];

   // ---------------- event monitor ----------------
   int         cyc = 0;
   logic       busy_d = 1'b0;
   logic       ferr_d = 1'b0;
   int         busy_rise_q[$];
   int         busy_fall_q[$];
   int         strobe_q[$];
   int         load_q[$];
   int         ferr_rise_q[$];
   int         ferr_fall_q[$];
   int         overlap_cnt = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   always @(negedge clk) begin
      cyc++;
      if (busy === 1'b1 && busy_d === 1'b0) busy_rise_q.push_back(cyc);
      if (busy === 1'b0 && busy_d === 1'b1) busy_fall_q.push_back(cyc);
      if (framing_error === 1'b1 && ferr_d === 1'b0) ferr_rise_q.push_back(cyc);
      if (framing_error === 1'b0 && ferr_d === 1'b1) ferr_fall_q.push_back(cyc);
      busy_d = busy;
      ferr_d = framing_error;
      if (shift_strobe === 1'b1) strobe_q.push_back(cyc);
      if (load_buffer === 1'b1) begin
         load_q.push_back(cyc);
         rx_q.push_back(sr[7:0]);
      end
      if (shift_strobe === 1'b1 && load_buffer === 1'b1) overlap_cnt++;
   end

   // ---------------- helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int q_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1000;
   endfunction

   task automatic clear_logs();
      busy_rise_q.delete();
      busy_fall_q.delete();
      strobe_q.delete();
      load_q.delete();
      ferr_rise_q.delete();
      ferr_fall_q.delete();
      rx_q.delete();
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop);
      logic [9:0] bits;
      bits = {stop, data, 1'b0};
      for (int b = 0; b < 10; b++) begin
         serial_in = bits[b];
         tick(CPB);
      end
   endtask

   task automatic check_bytes(input string tag);
      logic [7:0] e;
      logic [7:0] got;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
         chk(tag, {24'd0, got}, {24'd0, e});
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int         t;
      logic [9:0] ab;

      // Reset with the line low: nothing may start.
      rst       = 1'b1;
      serial_in = 1'b0;
      tick(2);
      chk("rst_busy",   {31'd0, busy},          32'd0);
      chk("rst_strobe", {31'd0, shift_strobe},  32'd0);
      chk("rst_load",   {31'd0, load_buffer},   32'd0);
      chk("rst_ferr",   {31'd0, framing_error}, 32'd0);
      rst       = 1'b0;
      serial_in = 1'b1;
      tick(5);
      chk("rst_release_busy",  {31'd0, busy},      32'd0);
      chk("rst_release_start", busy_rise_q.size(), 32'd0);

      // Good frame 0xA5.
      clear_logs();
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      tick(5);
      chk("good_strobes",     strobe_q.size(), 32'd9);
      chk("good_first_strobe", q_at(strobe_q, 0) - q_at(busy_rise_q, 0), 32'd14);
      chk("good_strobe_span", q_at(strobe_q, 8) - q_at(strobe_q, 0), 32'd80);
      chk("good_loads",       load_q.size(), 32'd1);
      chk("good_load_delay",  q_at(load_q, 0) - q_at(strobe_q, 8), 32'd2);
      chk("good_idle_at",     q_at(busy_fall_q, 0) - q_at(busy_rise_q, 0), 32'd97);
      chk("good_ferr",        {31'd0, framing_error}, 32'd0);
      check_bytes("good_byte");

      // 3-cycle glitch: start rejected after HALF cycles in START.
      clear_logs();
      serial_in = 1'b0;
      tick(3);
      serial_in = 1'b1;
      tick(20);
      chk("glitch_entered",  busy_rise_q.size(), 32'd1);
      chk("glitch_idle_at",  q_at(busy_fall_q, 0) - q_at(busy_rise_q, 0), 32'd5);
      chk("glitch_strobes",  strobe_q.size(), 32'd0);
      chk("glitch_loads",    load_q.size(), 32'd0);
      chk("glitch_ferr",     {31'd0, framing_error}, 32'd0);

      // Frame 0x3C with a bad stop bit.
      clear_logs();
      send_frame(8'h3C, 1'b0);
      serial_in = 1'b1;
      tick(20);
      chk("badstop_strobes", strobe_q.size(), 32'd9);
      chk("badstop_loads",   load_q.size(), 32'd0);
      chk("badstop_ferr_at", q_at(ferr_rise_q, 0) - q_at(busy_rise_q, 0), 32'd96);
      chk("badstop_idle_at", q_at(busy_fall_q, 0) - q_at(busy_rise_q, 0), 32'd96);
      chk("badstop_ferr_held", {31'd0, framing_error}, 32'd1);

      // Back-to-back 0x55 then 0xFF; the first start edge also clears the flag.
      clear_logs();
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hFF);
      send_frame(8'h55, 1'b1);
      chk("b2b_ferr_clear_at", q_at(ferr_fall_q, 0) - q_at(busy_rise_q, 0), 32'd0);
      chk("b2b_ferr_cleared",  {31'd0, framing_error}, 32'd0);
      send_frame(8'hFF, 1'b1);
      tick(5);
      chk("b2b_frames",   busy_rise_q.size(), 32'd2);
      chk("b2b_spacing",  q_at(busy_rise_q, 1) - q_at(busy_rise_q, 0), 32'd100);
      chk("b2b_strobes",  strobe_q.size(), 32'd18);
      chk("b2b_loads",    load_q.size(), 32'd2);
      chk("b2b_overlap",  overlap_cnt, 32'd0);
      check_bytes("b2b_byte");

      // Reset after the 4th strobe of an aborted frame, then receive 0x81.
      clear_logs();
      ab = {1'b1, 8'hC3, 1'b0};
      t  = 0;
      while (t < 100 && strobe_q.size() < 4) begin
         serial_in = ab[t / CPB];
         tick(1);
         t++;
      end
      chk("abort_reached_4", strobe_q.size(), 32'd4);
      rst       = 1'b1;
      serial_in = 1'b1;
      tick(1);
      chk("abort_busy_next",   {31'd0, busy},         32'd0);
      chk("abort_strobe_next", {31'd0, shift_strobe}, 32'd0);
      rst = 1'b0;
      tick(30);
      chk("abort_no_more_strobes", strobe_q.size(), 32'd4);
      chk("abort_no_load",         load_q.size(),   32'd0);

      clear_logs();
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      tick(5);
      chk("after_abort_strobes", strobe_q.size(), 32'd9);
      chk("after_abort_first",   q_at(strobe_q, 0) - q_at(busy_rise_q, 0), 32'd14);
      chk("after_abort_loads",   load_q.size(), 32'd1);
      chk("after_abort_ferr",    {31'd0, framing_error}, 32'd0);
      check_bytes("after_abort_byte");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side control for the UART receiver.
- Synchronizes the raw serial line, detects and qualifies the start bit, and times mid-bit sampling.
- Issues one shift_strobe per bit to the downstream 9-bit shift register: 8 data bits plus the stop bit.
- After the stop bit arrives back from that register, it either pulses load_buffer to the RX data buffer or flags a framing error.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per serial bit period; legal range >= 4. HALF = floor(CLKS_PER_BIT/2).
- NUM_BITS, 9, strobes per frame (8 data + 1 stop); legal range >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- serial_in  input  1  raw asynchronous RX line; idle high
- stop_bit  input  1  MSB of the downstream shift register; the stop bit once the frame is shifted in
- shift_strobe  output  1  one-cycle pulse; shift register samples serial line
- load_buffer  output  1  one-cycle pulse; RX buffer captures packet_data
- framing_error  output  1  sticky flag; last frame's stop bit was 0
- busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE.
  - Timer and bit counter go to 0.
  - Both synchronizer flops and the edge-detect flop go to 1.
  - shift_strobe, load_buffer, framing_error and busy all go to 0.
  - Reset applies immediately mid-frame; no further strobe or load occurs for the aborted frame.
- Synchronizer: 2-flop chain on serial_in gives rx_s. A third flop gives rx_prev. start_edge = rx_prev & ~rx_s.
- States: IDLE, START, RECEIVE, CHECK, LOAD.
- IDLE:
  - On start_edge go to START; timer=0, bit counter=0, framing_error cleared.
  - A line held low produces no start_edge, so there is no retrigger.
- START:
  - Timer increments each cycle.
  - At timer==HALF-1, sample rx_s.
  - rx_s=1 (glitch): go to IDLE. No strobe is issued and framing_error stays 0.
  - rx_s=0: go to RECEIVE with timer=0.
- RECEIVE:
  - Timer counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - shift_strobe=1 in exactly the cycle where timer==CLKS_PER_BIT-1; bit counter increments in that cycle.
  - When the strobe that makes the count NUM_BITS is issued, go to CHECK next cycle.
- CHECK (1 cycle):
  - stop_bit now reflects the final shift.
  - stop_bit=1: go to LOAD.
  - stop_bit=0: set framing_error and go to IDLE; load_buffer is not pulsed.
- LOAD (1 cycle): load_buffer=1, then go to IDLE.
- Timing, with cycle 0 = first cycle in START:
  - Start qualified at cycle HALF-1.
  - Strobe k (k=1..NUM_BITS) at cycle HALF-1+k*CLKS_PER_BIT.
  - CHECK at the cycle after the last strobe; LOAD at the cycle after that.
  - For CLKS_PER_BIT=10: strobes at 14,24,...,94; CHECK=95; LOAD=96; IDLE=97.
- Output encoding:
  - shift_strobe and load_buffer are never high in the same cycle.
  - busy is a Moore output: high in START, RECEIVE, CHECK and LOAD.
- framing_error holds until reset or the next start_edge accepted in IDLE. It is not cleared by a rejected glitch in START, because it was already cleared on entry to START.
- A start_edge during START, RECEIVE, CHECK or LOAD is ignored. The next frame's edge is accepted in IDLE, so back-to-back frames with one stop bit are received.
- Widths:
  - Timer width is clog2(CLKS_PER_BIT).
  - Bit counter width is clog2(NUM_BITS+1).
  - No counter exceeds its terminal value.

Test Plan:
- All tests use CLKS_PER_BIT=10.
- Reset: hold rst=1 for 2 cycles with serial_in=0 → all outputs 0, busy=0. Release with serial_in=1 → no start detected.
- Good frame 0xA5 with stop=1, bits 10 clk each → 9 shift_strobe pulses spaced 10 cycles apart (first 14 cycles after START entry). load_buffer pulses once, 2 cycles after the last strobe. framing_error=0. Downstream register holds 0xA5.
- Glitch: serial_in low for 3 cycles, then high → FSM returns to IDLE; zero strobes, no load, framing_error=0.
- Bad stop: frame 0x3C with stop bit 0 → 9 strobes, no load_buffer, framing_error=1 from the CHECK+1 cycle. The flag stays 1 while idle and clears at the next start edge.
- Back-to-back: frames 0x55 then 0xFF, with no idle between the stop bit and the next start bit → two load_buffer pulses and 18 strobes total.
- Mid-frame reset: assert rst after the 4th strobe → next cycle busy=0 and no further strobes. The next full frame 0x81 is received normally.
